// File: rtl/rgb_to_mono_packer_pkg.sv
// Shared pixel definitions: channel width, luma weights and the luma helper.
package rgb_to_mono_packer_pkg;

    localparam int CH_W       = 8;
    localparam int LUMA_R     = 77;
    localparam int LUMA_G     = 150;
    localparam int LUMA_B     = 29;
    localparam int LUMA_SHIFT = 8;
    // Weights sum to 256, so 255*256 is the largest sum and 16 bits never overflow.
    localparam int SUM_W      = 16;

    typedef logic [CH_W-1:0] chan_t;

    typedef struct packed {
        chan_t r;
        chan_t g;
        chan_t b;
    } rgb_t;

    // Integer BT.601-style luma, result 0..255.
    function automatic chan_t luma(input rgb_t px);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(px.r) * SUM_W'(LUMA_R)
            + SUM_W'(px.g) * SUM_W'(LUMA_G)
            + SUM_W'(px.b) * SUM_W'(LUMA_B);
        return chan_t'(sum >> LUMA_SHIFT);
    endfunction

endpackage

// File: rtl/rgb_luma_threshold.sv
// Combinational luma and threshold compare for one RGB pixel.
module rgb_luma_threshold
    import rgb_to_mono_packer_pkg::*;
(
    input  rgb_t  pixel_i,
    input  chan_t threshold_i,
    output logic  bit_o
);

    chan_t y;

    assign y     = luma(pixel_i);
    assign bit_o = (y >= threshold_i);

endmodule

// File: rtl/rgb_to_mono_packer.sv
// RGB pixel stream -> 1-bit luma threshold -> MSB-first packed words.
module rgb_to_mono_packer
    import rgb_to_mono_packer_pkg::*;
#(
    parameter int PACK_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH_W-1:0]           red_in,
    input  logic [CH_W-1:0]           green_in,
    input  logic [CH_W-1:0]           blue_in,
    input  logic                      in_last,
    input  logic [CH_W-1:0]           threshold,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PACK_W-1:0]         out_data,
    output logic [$clog2(PACK_W):0]   out_count,
    output logic                      out_last
);

    localparam int             CW    = $clog2(PACK_W);
    localparam logic [CW-1:0]  LASTP = CW'(PACK_W - 1);

    rgb_t               px;
    logic               px_bit;
    logic               accept, emit, s1_consume;
    logic [CW-1:0]      pos;
    logic [PACK_W-1:0]  word;

    logic               s1_valid_q, s1_bit_q, s1_last_q;
    logic [PACK_W-1:0]  acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [PACK_W-1:0]  out_data_q, out_data_d;
    logic [CW:0]        out_count_q, out_count_d;
    logic               out_last_q, out_last_d;

    assign px = '{r: red_in, g: green_in, b: blue_in};

    rgb_luma_threshold u_luma (
        .pixel_i     (px),
        .threshold_i (threshold),
        .bit_o       (px_bit)
    );

    // Handshake: s1 may only move into the packer if an emitted word has somewhere to go.
    assign emit       = s1_valid_q && ((cnt_q == LASTP) || s1_last_q);
    assign s1_consume = s1_valid_q && (!emit || !out_valid_q || out_ready);
    assign in_ready   = !reset && (!s1_valid_q || s1_consume);
    assign accept     = in_valid && in_ready;

    // Accumulator with the pending s1 bit dropped into its MSB-first slot.
    assign pos = LASTP - cnt_q;
    always_comb begin
        word      = acc_q;
        word[pos] = s1_bit_q;
    end

    // Stage 1: register the thresholded bit on accept, release it when consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_bit_q   <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_bit_q   <= px_bit;
            s1_last_q  <= in_last;
        end else if (s1_consume) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Packer next state: append the bit, or clear when the word leaves.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (s1_consume) begin
            if (emit) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = word;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Output register next state: a new word wins over a same-edge drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        if (s1_consume && emit) begin
            out_valid_d = 1'b1;
            out_data_d  = word;
            out_count_d = (CW+1)'(cnt_q) + (CW+1)'(1);
            out_last_d  = s1_last_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_count_d = '0;
            out_last_d  = 1'b0;
        end
    end

    // Packer and output state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;

endmodule
